folded_threshold_voter: RTL and testbench

// - Parametrised, folded successor to the flat combinational Maj43 block: decides popcount(x) >= THRESH

---
 rtl/folded_threshold_voter.sv | 145 ++++++++++++++
 tb/tb_folded_threshold_voter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/folded_threshold_voter.sv
// Folded threshold voter: decides popcount(x) >= THRESH over an N-bit vector
// by summing one W-bit chunk per clock. Valid/ready handshake on both sides.
// Optional build macro FOLDED_THRESHOLD_EARLY_EXIT_EN: leave the accumulate
// phase as soon as the decision can no longer change (variable latency).
module folded_threshold_voter #(
    parameter int unsigned N      = 43,
    parameter int unsigned W      = 8,
    parameter int unsigned THRESH = (N + 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               x_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       y_o,
    output logic [$clog2(N+1)-1:0]     count_o
);

    localparam int unsigned NCH = (N + W - 1) / W;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW  = NCH * W;

    localparam logic [CW:0] THRESH_C = CW1'(THRESH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          y_q, y_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] padded;
    logic [W-1:0]  chunk;
    logic [CW-1:0] chunk_cnt;
    logic [CW-1:0] acc_new;
    logic          at_thresh;
    logic          last_chunk;
    logic          exit_now;

    // Select the current chunk (zero-padded above N-1) and add its popcount
    always_comb begin
        padded              = '0;
        padded[N-1:0]       = vec_q;
        chunk               = padded[int'(idx_q) * W +: W];
        chunk_cnt           = '0;
        for (int b = 0; b < int'(W); b++) begin
            chunk_cnt = chunk_cnt + CW'(chunk[b]);
        end
        acc_new    = acc_q + chunk_cnt;
        at_thresh  = ({1'b0, acc_new} >= THRESH_C);
        last_chunk = (idx_q == IW'(NCH - 1));
    end

`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
    int summed;
    int rem;
    logic below;

    // Decision is settled once the threshold is reached or even all remaining
    // bits set could not reach it
    always_comb begin
        summed   = (int'(idx_q) + 1) * int'(W);
        rem      = (summed >= int'(N)) ? 0 : int'(N) - summed;
        below    = (int'(acc_new) + rem) < int'(THRESH);
        exit_now = last_chunk || at_thresh || below;
    end
`else
    // Fixed latency: leave only after the last chunk
    always_comb begin
        exit_now = last_chunk;
    end
`endif

    // Next-state logic for the IDLE -> ACC -> DONE handshake sequence
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    vec_d   = x_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = acc_new;
                idx_d = idx_q + 1'b1;
                if (exit_now) begin
                    // Output registers only ever change here
                    y_d     = at_thresh;
                    count_d = acc_new;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

    // Handshake flags decode directly from the state register
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        y_o       = y_q;
        count_o   = count_q;
    end

endmodule

// File: tb/tb_folded_threshold_voter.sv
// Self-checking bench for folded_threshold_voter: default 43/8/22 instance and
// a small 5/2/3 instance. Honours FOLDED_THRESHOLD_EARLY_EXIT_EN if defined.
module tb_folded_threshold_voter;

`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, y;
    logic [42:0] x;
    logic [5:0]  cnt;

    logic        in_valid5, in_ready5, out_valid5, out_ready5, y5;
    logic [4:0]  x5;
    logic [2:0]  cnt5;

    folded_threshold_voter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_i(x),
        .out_valid(out_valid), .out_ready(out_ready), .y_o(y), .count_o(cnt)
    );

    folded_threshold_voter #(.N(5), .W(2), .THRESH(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .x_i(x5),
        .out_valid(out_valid5), .out_ready(out_ready5), .y_o(y5), .count_o(cnt5)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One transaction on the default instance; lat counts edges after accept
    task automatic run0(input logic [42:0] v, output logic gy, output int gc, output int lat);
        @(negedge clk);
        x = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout0", 0, 1);
        gy = y;
        gc = int'(cnt);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run5(input logic [4:0] v, output logic gy, output int gc, output int lat);
        @(negedge clk);
        x5 = v;
        in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        lat = 0;
        while (!out_valid5 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid5) check("timeout5", 0, 1);
        gy = y5;
        gc = int'(cnt5);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [42:0] x;
        logic        y;
        int          cnt;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0] x;
        logic       y;
        int         cnt;
        int         lat;
    } vec5_t;

    initial begin
        vec_t        tbl[4];
        vec5_t       tbl5[2];
        logic        gy, hy;
        int          gc, hc, lat, pc;
        logic [42:0] rv;
        logic [4:0]  v5;

        tbl[0] = '{43'h0,            1'b0, 0,             EE ? 3 : 6};
        tbl[1] = '{43'h3F_FFFF,      1'b1, 22,            EE ? 3 : 6};
        tbl[2] = '{43'h1F_FFFF,      1'b0, 21,            6};
        tbl[3] = '{43'h7FF_FFFF_FFFF, 1'b1, EE ? 24 : 43, EE ? 3 : 6};
        tbl5[0] = '{5'b10101, 1'b1, 3,          3};
        tbl5[1] = '{5'b10001, 1'b0, EE ? 1 : 2, EE ? 2 : 3};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; x = '0;
        in_valid5 = 1'b0; out_ready5 = 1'b1; x5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_count", cnt, 0);
        check("rst_in_ready5", in_ready5, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run0(tbl[i].x, gy, gc, lat);
            check($sformatf("tbl%0d_y", i), gy, tbl[i].y);
            check($sformatf("tbl%0d_cnt", i), gc, tbl[i].cnt);
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_idle", i), in_ready, 1);
        end

        // Random vectors against popcount model
        for (int i = 0; i < 40; i++) begin
            rv = {11'($urandom), 32'($urandom)};
            if (i % 4 == 1) rv = rv & {11'($urandom), 32'($urandom)};
            if (i % 4 == 2) rv = rv | {11'($urandom), 32'($urandom)};
            pc = $countones(rv);
            run0(rv, gy, gc, lat);
            check("rand_y", gy, (pc >= 22) ? 1 : 0);
`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
            check("rand_cnt_bound", (gc <= pc) ? 1 : 0, 1);
            check("rand_lat_bound", (lat >= 1 && lat <= 6) ? 1 : 0, 1);
`else
            check("rand_cnt", gc, pc);
            check("rand_lat", lat, 6);
`endif
        end

        // Back-pressure in DONE: outputs stable, extra in_valid ignored
        out_ready = 1'b0;
        run0(43'h7FF_FFFF_FFFF, hy, hc, lat);
        check("hold_y", hy, 1);
        check("hold_cnt", hc, EE ? 24 : 43);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 43'h0;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_y_stable", y, hy);
            check("hold_cnt_stable", cnt, hc);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Asynchronous reset in the middle of accumulation
        @(negedge clk);
        x = 43'h7FF_FFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midacc_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_count", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(43'h3F_FFFF, gy, gc, lat);
        check("postrst_y", gy, 1);
        check("postrst_cnt", gc, 22);

        // Small instance: directed, then exhaustive
        for (int i = 0; i < 2; i++) begin
            run5(tbl5[i].x, gy, gc, lat);
            check($sformatf("n5_tbl%0d_y", i), gy, tbl5[i].y);
            check($sformatf("n5_tbl%0d_cnt", i), gc, tbl5[i].cnt);
            check($sformatf("n5_tbl%0d_lat", i), lat, tbl5[i].lat);
        end
        for (int v = 0; v < 32; v++) begin
            v5 = 5'(v);
            pc = $countones(v5);
            run5(v5, gy, gc, lat);
            check("n5_all_y", gy, (pc >= 3) ? 1 : 0);
`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
            check("n5_all_cnt_bound", (gc <= pc) ? 1 : 0, 1);
`else
            check("n5_all_cnt", gc, pc);
            check("n5_all_lat", lat, 3);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
